// File: rtl/rotary_encoder_emulator.sv
// Quadrature rotA/rotB generator replaying a saturating signed queue of
// Left/Right detent requests, one four-phase detent at a time.
module rotary_encoder_emulator #(
  parameter int PHASE_CYCLES = 50000,
  parameter int PEND_W       = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Left,
  input  logic                     Right,
  output logic                     rotA,
  output logic                     rotB,
  output logic                     Busy,
  output logic signed [PEND_W-1:0] Pending,
  output logic                     Overflow
);

  localparam int TIMER_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYCLES - 1);
  localparam logic signed [PEND_W:0] PEND_MAX = (PEND_W+1)'((1 << (PEND_W-1)) - 1);
  localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PEND_W:0] PEND_ONE = (PEND_W+1)'(1);

  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4} state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic                 dir_r;

  logic                 phase_done;
  logic                 launch_pt;
  logic                 launch_cw;
  logic                 launch_ccw;
  logic signed [PEND_W:0] pend_launch;
  logic signed [PEND_W:0] pend_next;
  logic                 drop;

  // Saturating one-step update of the queue; flags a request that would overflow.
  function automatic logic signed [PEND_W:0] sat_step(
    input  logic signed [PEND_W:0] val,
    input  logic                   up,
    input  logic                   dn,
    output logic                   dropped
  );
    logic signed [PEND_W:0] res;
    res     = val;
    dropped = 1'b0;
    if (up && !dn) begin
      if (val == PEND_MAX) dropped = 1'b1;
      else                 res = val + PEND_ONE;
    end else if (dn && !up) begin
      if (val == PEND_MIN) dropped = 1'b1;
      else                 res = val - PEND_ONE;
    end
    return res;
  endfunction

  assign phase_done = (timer == TIMER_LAST);
  assign launch_pt  = (state == IDLE) || ((state == P4) && phase_done);
  assign launch_cw  = launch_pt && (Pending > 0);
  assign launch_ccw = launch_pt && (Pending < 0);

  // A launch consumes one queued detent before the new request is applied.
  always_comb begin
    pend_launch = {Pending[PEND_W-1], Pending};
    drop        = 1'b0;
    if (launch_cw)       pend_launch = pend_launch - PEND_ONE;
    else if (launch_ccw) pend_launch = pend_launch + PEND_ONE;
    pend_next = sat_step(pend_launch, Right, Left, drop);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      timer    <= '0;
      dir_r    <= 1'b0;
      rotA     <= 1'b0;
      rotB     <= 1'b0;
      Busy     <= 1'b0;
      Pending  <= '0;
      Overflow <= 1'b0;
    end else begin
      Pending  <= pend_next[PEND_W-1:0];
      Overflow <= drop;
      if (launch_cw || launch_ccw) begin
        state         <= P1;
        timer         <= '0;
        dir_r         <= launch_cw;
        Busy          <= 1'b1;
        {rotA, rotB}  <= launch_cw ? 2'b10 : 2'b01;
      end else if (state == IDLE) begin
        timer        <= '0;
        Busy         <= 1'b0;
        {rotA, rotB} <= 2'b00;
      end else if (!phase_done) begin
        timer <= timer + TIMER_W'(1);
      end else begin
        // Gray sequence: only one channel toggles per phase step.
        timer <= '0;
        case (state)
          P1: begin
            state        <= P2;
            {rotA, rotB} <= 2'b11;
          end
          P2: begin
            state        <= P3;
            {rotA, rotB} <= dir_r ? 2'b01 : 2'b10;
          end
          P3: begin
            state        <= P4;
            {rotA, rotB} <= 2'b00;
          end
          default: begin
            state        <= IDLE;
            Busy         <= 1'b0;
            {rotA, rotB} <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule
